// File: rtl/rv_wb_pkg.sv
// Shared encodings for the writeback unit: request kinds, load funct3 codes, FSM states.
package rv_wb_pkg;

    typedef enum logic [1:0] {
        KindNone = 2'd0,
        KindAlu  = 2'd1,
        KindLoad = 2'd2,
        KindRsvd = 2'd3
    } kind_e;

    localparam logic [2:0] F3Lb  = 3'd0;
    localparam logic [2:0] F3Lh  = 3'd1;
    localparam logic [2:0] F3Lw  = 3'd2;
    localparam logic [2:0] F3Lbu = 3'd4;
    localparam logic [2:0] F3Lhu = 3'd5;

    typedef enum logic {
        StIdle    = 1'b0,
        StWaitMem = 1'b1
    } state_e;

endpackage

// File: rtl/load_align.sv
// Load extraction/extension from an aligned memory word, plus misalignment/illegal detection.
module load_align
    import rv_wb_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  a,
    input  logic [31:0] mem_rdata,
    output logic [31:0] data,
    output logic        misaligned
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = mem_rdata[{a, 3'b000} +: 8];
    assign half_sel = mem_rdata[{a[1], 4'b0000} +: 16];

    // Select and extend by load type; unknown funct3 codes are reported as illegal
    always_comb begin
        data       = '0;
        misaligned = 1'b0;
        case (funct3)
            F3Lb:  data = {{24{byte_sel[7]}}, byte_sel};
            F3Lbu: data = {24'd0, byte_sel};
            F3Lh: begin
                data       = {{16{half_sel[15]}}, half_sel};
                misaligned = a[0];
            end
            F3Lhu: begin
                data       = {16'd0, half_sel};
                misaligned = a[0];
            end
            F3Lw: begin
                data       = mem_rdata;
                misaligned = (a != 2'd0);
            end
            default: misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: retires ALU results directly and waits for memory on loads.
module writeback_unit
    import rv_wb_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_kind,
    input  logic [4:0]       in_rd,
    input  logic [2:0]       in_funct3,
    input  logic [31:0]      in_result,
    input  logic             mem_rsp_valid,
    input  logic [31:0]      mem_rdata,
    output logic [4:0]       w_address,
    output logic             load,
    output logic [31:0]      w_in,
    output logic             fault,
    output logic [CNT_W-1:0] retired
);

    state_e      state;
    logic [4:0]  rd_q;
    logic [2:0]  funct3_q;
    logic [1:0]  a_q;

    logic [2:0]  align_funct3;
    logic [1:0]  align_a;
    logic [31:0] align_data;
    logic        align_misaligned;

    assign in_ready = (state == StIdle);

    // One aligner serves both uses: fault check on the incoming request in IDLE,
    // data extraction from the latched request in WAIT_MEM
    assign align_funct3 = (state == StIdle) ? in_funct3 : funct3_q;
    assign align_a      = (state == StIdle) ? in_result[1:0] : a_q;

    load_align u_load_align (
        .funct3     (align_funct3),
        .a          (align_a),
        .mem_rdata  (mem_rdata),
        .data       (align_data),
        .misaligned (align_misaligned)
    );

    // FSM with registered write port, fault pulse and retire counter
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= StIdle;
            load      <= 1'b0;
            fault     <= 1'b0;
            w_address <= '0;
            w_in      <= '0;
            retired   <= '0;
            rd_q      <= '0;
            funct3_q  <= '0;
            a_q       <= '0;
        end else begin
            load  <= 1'b0;
            fault <= 1'b0;
            case (state)
                StIdle: begin
                    if (in_valid) begin
                        retired <= retired + CNT_W'(1);
                        case (in_kind)
                            KindAlu: begin
                                w_address <= in_rd;
                                w_in      <= in_result;
                                load      <= (in_rd != 5'd0);
                            end
                            KindLoad: begin
                                if (align_misaligned) begin
                                    fault <= 1'b1;
                                end else begin
                                    rd_q     <= in_rd;
                                    funct3_q <= in_funct3;
                                    a_q      <= in_result[1:0];
                                    state    <= StWaitMem;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                StWaitMem: begin
                    if (mem_rsp_valid) begin
                        w_address <= rd_q;
                        w_in      <= align_data;
                        load      <= (rd_q != 5'd0);
                        state     <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_writeback_unit.sv
// Directed self-checking bench for writeback_unit.
module tb_writeback_unit;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_kind;
    logic [4:0]  in_rd;
    logic [2:0]  in_funct3;
    logic [31:0] in_result;
    logic        mem_rsp_valid;
    logic [31:0] mem_rdata;
    logic [4:0]  w_address;
    logic        load;
    logic [31:0] w_in;
    logic        fault;
    logic [31:0] retired;

    int n_checks;
    int n_errors;

    writeback_unit #(.CNT_W(32)) dut (
        .clock         (clock),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_kind       (in_kind),
        .in_rd         (in_rd),
        .in_funct3     (in_funct3),
        .in_result     (in_result),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rdata     (mem_rdata),
        .w_address     (w_address),
        .load          (load),
        .w_in          (w_in),
        .fault         (fault),
        .retired       (retired)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic req(input logic [1:0] kind, input logic [4:0] rd, input logic [2:0] f3,
                       input logic [31:0] res);
        in_valid  = 1'b1;
        in_kind   = kind;
        in_rd     = rd;
        in_funct3 = f3;
        in_result = res;
    endtask

    logic [31:0] exp_ret;
    logic [31:0] b2b_data [4];

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        exp_ret       = 0;
        reset         = 1'b0;
        in_valid      = 1'b0;
        in_kind       = 2'd0;
        in_rd         = 5'd0;
        in_funct3     = 3'd0;
        in_result     = 32'd0;
        mem_rsp_valid = 1'b0;
        mem_rdata     = 32'd0;
        b2b_data[0] = 32'h1111_0001;
        b2b_data[1] = 32'h2222_0002;
        b2b_data[2] = 32'h3333_0003;
        b2b_data[3] = 32'h4444_0004;

        // Reset state, before and after clock edges
        #2;
        check("rst_load", {31'd0, load}, 32'd0);
        check("rst_fault", {31'd0, fault}, 32'd0);
        check("rst_waddr", {27'd0, w_address}, 32'd0);
        check("rst_win", w_in, 32'd0);
        check("rst_retired", retired, 32'd0);
        check("rst_ready", {31'd0, in_ready}, 32'd1);
        tick();
        tick();
        reset = 1'b1;
        tick();

        // ALU rd=5
        req(2'd1, 5'd5, 3'd0, 32'hDEAD_BEEF);
        tick();
        in_valid = 1'b0;
        exp_ret++;
        check("alu_load", {31'd0, load}, 32'd1);
        check("alu_waddr", {27'd0, w_address}, 32'd5);
        check("alu_win", w_in, 32'hDEAD_BEEF);
        tick();
        check("alu_load_off", {31'd0, load}, 32'd0);
        check("alu_win_hold", w_in, 32'hDEAD_BEEF);
        check("alu_retired", retired, exp_ret);

        // mem_rsp_valid in IDLE is ignored
        mem_rsp_valid = 1'b1;
        mem_rdata     = 32'hCAFE_F00D;
        tick();
        mem_rsp_valid = 1'b0;
        check("idle_rsp_load", {31'd0, load}, 32'd0);
        check("idle_rsp_win", w_in, 32'hDEAD_BEEF);

        // LB at 0x103 with 3 wait cycles, then LBU at the same address
        for (int k = 0; k < 2; k++) begin
            req(2'd2, 5'd7, (k == 0) ? 3'd0 : 3'd4, 32'h0000_0103);
            tick();
            in_valid = 1'b0;
            exp_ret++;
            check("ld_wait_ready", {31'd0, in_ready}, 32'd0);
            for (int w = 0; w < 3; w++) begin
                tick();
                check("ld_wait_load", {31'd0, load}, 32'd0);
            end
            mem_rsp_valid = 1'b1;
            mem_rdata     = 32'h80FF_0000;
            tick();
            mem_rsp_valid = 1'b0;
            check("ld_load", {31'd0, load}, 32'd1);
            check("ld_waddr", {27'd0, w_address}, 32'd7);
            check("ld_win", w_in, (k == 0) ? 32'hFFFF_FF80 : 32'h0000_0080);
            check("ld_ready", {31'd0, in_ready}, 32'd1);
            tick();
            check("ld_load_off", {31'd0, load}, 32'd0);
        end

        // LH at 0x101 and LW at 0x2 fault
        for (int k = 0; k < 2; k++) begin
            req(2'd2, 5'd9, (k == 0) ? 3'd1 : 3'd2, (k == 0) ? 32'h0000_0101 : 32'h0000_0002);
            tick();
            in_valid = 1'b0;
            exp_ret++;
            check("flt_pulse", {31'd0, fault}, 32'd1);
            check("flt_load", {31'd0, load}, 32'd0);
            check("flt_ready", {31'd0, in_ready}, 32'd1);
            tick();
            check("flt_pulse_end", {31'd0, fault}, 32'd0);
            check("flt_win", w_in, (k == 0) ? 32'h0000_0080 : 32'h0000_0080);
        end
        check("flt_retired", retired, exp_ret);

        // ALU rd=0: no write enable, index/data still update
        req(2'd1, 5'd0, 3'd0, 32'h0000_1234);
        tick();
        in_valid = 1'b0;
        exp_ret++;
        check("rd0_load", {31'd0, load}, 32'd0);
        check("rd0_waddr", {27'd0, w_address}, 32'd0);
        check("rd0_win", w_in, 32'h0000_1234);
        check("rd0_retired", retired, exp_ret);

        // NONE and reserved kinds retire without writing
        req(2'd0, 5'd3, 3'd0, 32'h5555_5555);
        tick();
        req(2'd3, 5'd4, 3'd0, 32'h6666_6666);
        check("none_load", {31'd0, load}, 32'd0);
        tick();
        in_valid = 1'b0;
        exp_ret += 2;
        check("rsvd_load", {31'd0, load}, 32'd0);
        check("rsvd_win", w_in, 32'h0000_1234);
        check("rsvd_retired", retired, exp_ret);

        // Reset while waiting for memory discards the load
        req(2'd2, 5'd10, 3'd2, 32'h0000_0100);
        tick();
        in_valid = 1'b0;
        check("rstw_ready", {31'd0, in_ready}, 32'd0);
        #2;
        reset = 1'b0;
        #1;
        check("rstw_async_ready", {31'd0, in_ready}, 32'd1);
        check("rstw_async_ret", retired, 32'd0);
        check("rstw_async_win", w_in, 32'd0);
        tick();
        reset = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rdata     = 32'h9999_9999;
        tick();
        mem_rsp_valid = 1'b0;
        check("rstw_load", {31'd0, load}, 32'd0);
        check("rstw_win", w_in, 32'd0);
        check("rstw_retired", retired, 32'd0);

        // Four back-to-back ALU writes
        for (int k = 0; k < 4; k++) begin
            req(2'd1, 5'(k + 1), 3'd0, b2b_data[k]);
            tick();
            check("b2b_load", {31'd0, load}, 32'd1);
            check("b2b_waddr", {27'd0, w_address}, 32'(k + 1));
            check("b2b_win", w_in, b2b_data[k]);
        end
        in_valid = 1'b0;
        tick();
        check("b2b_load_off", {31'd0, load}, 32'd0);
        check("b2b_retired", retired, 32'd4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
